rpn_stack_calc: RTL and testbench

- Parametrised RPN calculator core: operand stack of DEPTH entries, WIDTH bits each, driven by an opcode+data token stream.
- Sits between the keypad control state machine (receives built numbers and operator tokens) and the VGA buffer / 7-segment path (consumes answer).
- Replaces the fixed-width single-shot calculator slot.
- Adds configurable width and depth, a multi-cycle divider, error reporting and a ready/valid handshake.

---
 rtl/rpn_calc_pkg.sv | 27 ++
 rtl/rpn_stack_calc_seq_divider.sv | 63 ++++++
 rtl/rpn_stack_calc.sv | 218 +++++++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_calc_pkg.sv
// Shared encodings for the RPN calculator core: opcodes, error codes and FSM states.
package rpn_calc_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_EQ   = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_DIVZERO   = 2'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EXEC     = 2'd1;
  localparam logic [1:0] ST_DIV_BUSY = 2'd2;
  localparam logic [1:0] ST_ERROR    = 2'd3;

  // Two-operand arithmetic tokens; these all consume the top two stack entries.
  function automatic logic is_binary_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/rpn_stack_calc_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulses WIDTH cycles after start.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] div_reg;
  logic [CW-1:0]    cnt_reg;
  logic             run_reg;
  logic             done_reg;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // The dividend shifts out of quo_reg MSB-first while quotient bits shift in at the LSB.
  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign fits    = shifted >= {1'b0, div_reg};
  assign diff    = shifted[WIDTH-1:0] - div_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      div_reg  <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg <= '0;
        quo_reg <= dividend;
        div_reg <= divisor;
        cnt_reg <= '0;
        run_reg <= 1'b1;
      end else if (run_reg) begin
        rem_reg <= fits ? diff : shifted[WIDTH-1:0];
        quo_reg <= {quo_reg[WIDTH-2:0], fits};
        cnt_reg <= cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done     = done_reg;
  assign quotient = quo_reg;

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN calculator core: operand stack, single-cycle ADD/SUB/MUL, sequential DIV, sticky errors.
module rpn_stack_calc
  import rpn_calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] answer,
  output logic             answer_valid,
  output logic [WIDTH-1:0] top_value,
  output logic [CNT_W-1:0] depth_count,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] stack_reg [DEPTH];

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] answer_reg, answer_next;
  logic             answer_valid_reg, answer_valid_next;
  logic             err_reg, err_next;
  logic [1:0]       err_code_reg, err_code_next;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;

  logic [IDX_W-1:0] top_idx, sec_idx;
  logic [WIDTH-1:0] top_word, sec_word;
  logic [WIDTH-1:0] exec_result;
  logic             accept, empty, full, has_two;
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quotient;

  assign top_idx  = IDX_W'(count_reg - CNT_W'(1));
  assign sec_idx  = IDX_W'(count_reg - CNT_W'(2));
  assign top_word = stack_reg[top_idx];
  assign sec_word = stack_reg[sec_idx];

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign has_two = (count_reg >= CNT_W'(2));

  assign in_ready = (state_reg == ST_IDLE) || (state_reg == ST_ERROR);
  assign busy     = (state_reg == ST_EXEC) || (state_reg == ST_DIV_BUSY);
  assign accept   = in_valid && in_ready;

  // The divider loads on the accepting edge straight from the stack so the quotient is
  // ready WIDTH+1 edges later; a zero divisor never starts it.
  assign div_start = (state_reg == ST_IDLE) && accept && (in_op == OP_DIV) &&
                     has_two && (top_word != '0);

  always_comb begin
    exec_result = '0;
    case (op_reg)
      OP_ADD:  exec_result = b_reg + a_reg;
      OP_SUB:  exec_result = b_reg - a_reg;
      default: exec_result = b_reg * a_reg;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    a_next            = a_reg;
    b_next            = b_reg;
    op_next           = op_reg;
    answer_next       = answer_reg;
    answer_valid_next = 1'b0;
    err_next          = err_reg;
    err_code_next     = err_code_reg;
    wr_en             = 1'b0;
    wr_idx            = '0;
    wr_data           = '0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (in_op == OP_PUSH) begin
            if (full) begin
              state_next    = ST_ERROR;
              err_next      = 1'b1;
              err_code_next = ERR_OVERFLOW;
            end else begin
              wr_en      = 1'b1;
              wr_idx     = IDX_W'(count_reg);
              wr_data    = in_data;
              count_next = count_reg + CNT_W'(1);
            end
          end else if (is_binary_op(in_op)) begin
            if (!has_two) begin
              state_next    = ST_ERROR;
              err_next      = 1'b1;
              err_code_next = ERR_UNDERFLOW;
            end else begin
              a_next     = top_word;
              b_next     = sec_word;
              op_next    = in_op;
              state_next = (in_op == OP_DIV) ? ST_DIV_BUSY : ST_EXEC;
            end
          end else if (in_op == OP_EQ) begin
            if (empty) begin
              state_next    = ST_ERROR;
              err_next      = 1'b1;
              err_code_next = ERR_UNDERFLOW;
            end else begin
              answer_next       = top_word;
              answer_valid_next = 1'b1;
            end
          end else if (in_op == OP_CLR) begin
            count_next    = '0;
            answer_next   = '0;
            err_next      = 1'b0;
            err_code_next = ERR_NONE;
          end
        end
      end

      ST_EXEC: begin
        wr_en      = 1'b1;
        wr_idx     = sec_idx;
        wr_data    = exec_result;
        count_next = count_reg - CNT_W'(1);
        state_next = ST_IDLE;
      end

      ST_DIV_BUSY: begin
        if (a_reg == '0) begin
          state_next    = ST_ERROR;
          err_next      = 1'b1;
          err_code_next = ERR_DIVZERO;
        end else if (div_done) begin
          wr_en      = 1'b1;
          wr_idx     = sec_idx;
          wr_data    = div_quotient;
          count_next = count_reg - CNT_W'(1);
          state_next = ST_IDLE;
        end
      end

      default: begin
        // Error state swallows everything except CLR so the keypad never stalls.
        if (accept && (in_op == OP_CLR)) begin
          state_next    = ST_IDLE;
          count_next    = '0;
          answer_next   = '0;
          err_next      = 1'b0;
          err_code_next = ERR_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      count_reg        <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      op_reg           <= OP_PUSH;
      answer_reg       <= '0;
      answer_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
      err_code_reg     <= ERR_NONE;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      a_reg            <= a_next;
      b_reg            <= b_next;
      op_reg           <= op_next;
      answer_reg       <= answer_next;
      answer_valid_reg <= answer_valid_next;
      err_reg          <= err_next;
      err_code_reg     <= err_code_next;
    end
  end

  // Stack storage carries no reset; depth_count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stack_reg[wr_idx] <= wr_data;
    end
  end

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(sec_word),
    .divisor (top_word),
    .done    (div_done),
    .quotient(div_quotient)
  );

  assign answer       = answer_reg;
  assign answer_valid = answer_valid_reg;
  assign top_value    = empty ? '0 : top_word;
  assign depth_count  = count_reg;
  assign err          = err_reg;
  assign err_code     = err_code_reg;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Scoreboard bench for rpn_stack_calc: directed scenarios then random tokens against a queue-based stack model.
module tb_rpn_stack_calc;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BOUND = 200;

  localparam logic [2:0] PUSH = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3,
                         DIV = 3'd4, EQ = 3'd5, CLR = 3'd6, RSV = 3'd7;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = 3'd0;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] answer;
  logic             answer_valid;
  logic [WIDTH-1:0] top_value;
  logic [CNT_W-1:0] depth_count;
  logic             busy;
  logic             err;
  logic [1:0]       err_code;

  rpn_stack_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_data     (in_data),
    .answer      (answer),
    .answer_valid(answer_valid),
    .top_value   (top_value),
    .depth_count (depth_count),
    .busy        (busy),
    .err         (err),
    .err_code    (err_code)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_stk [$];
  bit               model_err = 1'b0;
  logic [1:0]       model_code = 2'd0;
  logic [WIDTH-1:0] sb_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_fault(input logic [1:0] code);
    model_err  = 1'b1;
    model_code = code;
  endtask

  // Reference behaviour of one accepted token, written in terms of a plain stack queue.
  task automatic model_apply(input logic [2:0] op, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] a, b, r;
    if (op == CLR) begin
      model_stk.delete();
      model_err  = 1'b0;
      model_code = 2'd0;
      return;
    end
    if (model_err) return;
    case (op)
      PUSH: begin
        if (model_stk.size() == DEPTH) model_fault(2'd1);
        else model_stk.push_back(d);
      end
      ADD, SUB, MUL, DIV: begin
        if (model_stk.size() < 2) model_fault(2'd2);
        else begin
          a = model_stk[model_stk.size()-1];
          b = model_stk[model_stk.size()-2];
          if (op == DIV && a == 0) model_fault(2'd3);
          else begin
            case (op)
              ADD:     r = b + a;
              SUB:     r = b - a;
              MUL:     r = b * a;
              default: r = b / a;
            endcase
            void'(model_stk.pop_back());
            void'(model_stk.pop_back());
            model_stk.push_back(r);
          end
        end
      end
      EQ: begin
        if (model_stk.size() == 0) model_fault(2'd2);
        else sb_q.push_back(model_stk[model_stk.size()-1]);
      end
      default: ;
    endcase
  endtask

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] d, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    while (!in_ready) begin
      @(negedge clk);
      waited++;
      if (waited > BOUND) begin
        chk("send_timeout", 64'(waited), 64'(BOUND));
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    model_apply(op, d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic put(input logic [2:0] op, input logic [WIDTH-1:0] d);
    int w;
    send(op, d, w);
  endtask

  task automatic count_not_ready(output int n);
    n = 0;
    while (!in_ready && n <= BOUND) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_model(input string name);
    int n;
    count_not_ready(n);
    if (n > BOUND) chk({name, "_ready_timeout"}, 64'(n), 64'(BOUND));
    chk({name, "_depth"}, 64'(depth_count), 64'(model_stk.size()));
    chk({name, "_top"}, 64'(top_value),
        (model_stk.size() == 0) ? 64'd0 : 64'(model_stk[model_stk.size()-1]));
    chk({name, "_err"}, 64'(err), 64'(model_err));
    chk({name, "_code"}, 64'(err_code), 64'(model_code));
  endtask

  // Monitor: every answer_valid pulse consumes one expected EQ result.
  always @(negedge clk) begin
    if (!reset && answer_valid) begin
      if (sb_q.size() == 0) chk("answer_unexpected", 64'(answer), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("answer", 64'(answer), 64'(sb_q.pop_front()));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, w;
    int r;
    logic [2:0] op;
    logic [WIDTH-1:0] d;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_depth", 64'(depth_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_answer", 64'(answer), 64'd0);
    chk("rst_aval", 64'(answer_valid), 64'd0);
    chk("rst_top", 64'(top_value), 64'd0);

    // ADD with one-cycle EXEC, then EQ pulse.
    put(PUSH, 12);
    put(PUSH, 30);
    put(ADD, 0);
    count_not_ready(n);
    chk("add_stall_cycles", 64'(n), 64'd1);
    put(EQ, 0);
    chk("eq_pulse_high", 64'(answer_valid), 64'd1);
    @(negedge clk);
    chk("eq_pulse_low", 64'(answer_valid), 64'd0);
    check_model("add");

    put(CLR, 0);
    put(PUSH, 7);
    put(PUSH, 10);
    put(SUB, 0);
    put(EQ, 0);
    check_model("sub");
    put(PUSH, 65536);
    put(PUSH, 65536);
    put(MUL, 0);
    check_model("mul_trunc");

    // DIV timing: result lands WIDTH+1 edges after acceptance.
    put(CLR, 0);
    put(PUSH, 100);
    put(PUSH, 7);
    put(DIV, 0);
    chk("div_busy", 64'(busy), 64'd1);
    count_not_ready(n);
    chk("div_stall_cycles", 64'(n), 64'(WIDTH + 1));
    chk("div_top", 64'(top_value), 64'd14);
    check_model("div");

    // Token offered during a divide must wait, then land intact.
    put(PUSH, 32'hDEAD_BEEF);
    put(PUSH, 16);
    put(DIV, 0);
    send(PUSH, 55, w);
    chk("held_wait", 64'(w), 64'(WIDTH + 1));
    check_model("held_push");

    // Divide by zero, dropped token, CLR recovery.
    put(CLR, 0);
    put(PUSH, 5);
    put(PUSH, 0);
    put(DIV, 0);
    check_model("divzero");
    put(ADD, 0);
    check_model("err_drop");
    put(CLR, 0);
    check_model("err_clr");

    for (int i = 0; i < DEPTH + 1; i++) put(PUSH, 32'(i + 1));
    check_model("overflow");
    put(CLR, 0);
    put(ADD, 0);
    check_model("underflow");
    put(CLR, 0);
    put(RSV, 0);
    check_model("reserved");

    // Reset in the middle of a divide.
    put(PUSH, 9);
    put(EQ, 0);
    put(PUSH, 100);
    put(DIV, 0);
    put(PUSH, 7);
    put(DIV, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_depth", 64'(depth_count), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_answer", 64'(answer), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_stk.delete();
    model_err  = 1'b0;
    model_code = 2'd0;
    put(PUSH, 3);
    check_model("post_rst");

    // Random token stream against the model.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) op = PUSH;
      else if (r < 50) op = ADD;
      else if (r < 58) op = SUB;
      else if (r < 66) op = MUL;
      else if (r < 74) op = DIV;
      else if (r < 86) op = EQ;
      else if (r < 92) op = CLR;
      else op = RSV;
      if (model_err && $urandom_range(0, 3) == 0) op = CLR;
      d = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 20));
      put(op, d);
      check_model($sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
